// File: rtl/heat_stir_ctrl.sv
// N-channel heater/stirrer controller: proportional heater PWM, soft-start motor PWM,
// sticky over-temperature fault and a per-channel IDLE/HEAT/HOLD/FAULT state machine.
module heat_stir_ctrl #(
    parameter int CH        = 2,
    parameter int TW        = 8,
    parameter int PW        = 8,
    parameter int PRESC     = 390,
    parameter int KP_SHIFT  = 3,
    parameter int BAND      = 2,
    parameter int RAMP_STEP = 4,
    parameter int T_MAX     = 160,
    parameter int T_HYST    = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CH-1:0]    en_i,
    input  logic             temp_valid_i,
    input  logic [CH*TW-1:0] temp_i,
    input  logic [CH*TW-1:0] setp_i,
    input  logic [CH*PW-1:0] vel_i,
    input  logic             fault_clr_i,
    output logic [CH-1:0]    heater_o,
    output logic [CH-1:0]    motor_o,
    output logic [CH-1:0]    fault_o,
    output logic [CH-1:0]    at_temp_o,
    output logic [CH*PW-1:0] mot_duty_o
);
    localparam int PCW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int EW  = (TW + KP_SHIFT > PW) ? TW + KP_SHIFT : PW;
    localparam logic [PW-1:0]        DUTY_MAX = {PW{1'b1}};
    localparam logic signed [TW:0]   BAND_S   = (TW+1)'(BAND);
    localparam logic [TW-1:0]        TRIP     = TW'(T_MAX);
    localparam logic [TW-1:0]        CLR_LIM  = TW'(T_MAX - T_HYST);
    localparam logic [PW-1:0]        STEP     = PW'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, HEAT, HOLD, FAULT} state_t;

    logic [PCW-1:0] presc_q, presc_d;
    logic [PW-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic           tick, pb;

    state_t         state_q     [CH];
    state_t         state_d     [CH];
    logic [TW-1:0]  temp_q      [CH];
    logic [TW-1:0]  temp_d      [CH];
    logic [PW-1:0]  heat_duty_q [CH];
    logic [PW-1:0]  heat_duty_d [CH];
    logic [PW-1:0]  mot_duty_q  [CH];
    logic [PW-1:0]  mot_duty_d  [CH];
    logic [CH-1:0]  heater_q, heater_d, motor_q, motor_d;

    // Shared PWM timebase: pb marks the last tick of a PWM period.
    always_comb begin
        tick      = (presc_q == PCW'(PRESC - 1));
        presc_d   = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        pb        = tick && (pwm_cnt_q == DUTY_MAX);
    end

    always_comb begin
        logic signed [TW:0] err;
        logic [EW-1:0]      err_sh;
        logic [PW-1:0]      raw, tgt;
        logic               in_band;
        err        = '0;
        err_sh     = '0;
        raw        = '0;
        tgt        = '0;
        in_band    = 1'b0;
        heater_d   = '0;
        motor_d    = '0;
        fault_o    = '0;
        at_temp_o  = '0;
        mot_duty_o = '0;
        for (int c = 0; c < CH; c++) begin
            err     = $signed({1'b0, setp_i[c*TW +: TW]}) - $signed({1'b0, temp_q[c]});
            err_sh  = EW'(err[TW-1:0]) << KP_SHIFT;
            in_band = (err <= BAND_S) && (err >= -BAND_S);
            if (err[TW] || err == '0)      raw = '0;
            else if (err_sh > EW'(DUTY_MAX)) raw = DUTY_MAX;
            else                           raw = err_sh[PW-1:0];

            temp_d[c]  = temp_valid_i ? temp_i[c*TW +: TW] : temp_q[c];

            state_d[c] = state_q[c];
            if (temp_q[c] >= TRIP) begin
                state_d[c] = FAULT;
            end else if (state_q[c] == FAULT) begin
                if (fault_clr_i && temp_q[c] < CLR_LIM) state_d[c] = IDLE;
            end else if (!en_i[c]) begin
                state_d[c] = IDLE;
            end else begin
                case (state_q[c])
                    IDLE:    state_d[c] = HEAT;
                    HEAT:    if (in_band)  state_d[c] = HOLD;
                    HOLD:    if (!in_band) state_d[c] = HEAT;
                    default: state_d[c] = state_q[c];
                endcase
            end

            // Duty only moves on period boundaries so each period is a clean PWM frame.
            heat_duty_d[c] = heat_duty_q[c];
            if (state_q[c] == IDLE || state_q[c] == FAULT || state_d[c] == FAULT)
                heat_duty_d[c] = '0;
            else if (pb)
                heat_duty_d[c] = raw;

            tgt           = en_i[c] ? vel_i[c*PW +: PW] : '0;
            mot_duty_d[c] = mot_duty_q[c];
            if (pb) begin
                if (mot_duty_q[c] < tgt)
                    mot_duty_d[c] = (tgt - mot_duty_q[c] < STEP) ? tgt : mot_duty_q[c] + STEP;
                else if (mot_duty_q[c] > tgt)
                    mot_duty_d[c] = (mot_duty_q[c] - tgt < STEP) ? tgt : mot_duty_q[c] - STEP;
            end

            // Gate on the next state so a trip or disable drops the heater one cycle earlier.
            heater_d[c] = (state_d[c] == HEAT || state_d[c] == HOLD) && (pwm_cnt_q < heat_duty_q[c]);
            motor_d[c]  = pwm_cnt_q < mot_duty_q[c];

            fault_o[c]               = (state_q[c] == FAULT);
            at_temp_o[c]             = (state_q[c] == HOLD);
            mot_duty_o[c*PW +: PW]   = mot_duty_q[c];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            heater_q  <= '0;
            motor_q   <= '0;
            for (int c = 0; c < CH; c++) begin
                state_q[c]     <= IDLE;
                temp_q[c]      <= '0;
                heat_duty_q[c] <= '0;
                mot_duty_q[c]  <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            heater_q  <= heater_d;
            motor_q   <= motor_d;
            for (int c = 0; c < CH; c++) begin
                state_q[c]     <= state_d[c];
                temp_q[c]      <= temp_d[c];
                heat_duty_q[c] <= heat_duty_d[c];
                mot_duty_q[c]  <= mot_duty_d[c];
            end
        end
    end

    assign heater_o = heater_q;
    assign motor_o  = motor_q;

endmodule

// File: tb/tb_heat_stir_ctrl.sv
// Bench for heat_stir_ctrl: directed test-plan scenarios plus random channel settings,
// checked per PWM period against a behavioural model of duty, ramp and channel mode.
module tb_heat_stir_ctrl;
    localparam int CH    = 2;
    localparam int TW    = 8;
    localparam int PW    = 8;
    localparam int PRESC = 2;
    localparam int P     = 256 * PRESC;

    localparam int S_IDLE = 0, S_HEAT = 1, S_HOLD = 2, S_FAULT = 3;
    localparam int GAIN = 8, BAND = 2, STEP = 4, T_MAX = 160, T_CLR = 150, DMAX = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH-1:0]    en_i = '0;
    logic             temp_valid = 1'b0;
    logic [CH*TW-1:0] temp_i = '0;
    logic [CH*TW-1:0] setp_i = '0;
    logic [CH*PW-1:0] vel_i = '0;
    logic             fault_clr = 1'b0;
    logic [CH-1:0]    heater_o, motor_o, fault_o, at_temp_o;
    logic [CH*PW-1:0] mot_duty_o;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int hc[CH], mc[CH];
    int m_temp[CH], n_temp[CH], m_setp[CH], m_vel[CH], m_en[CH], m_st[CH], m_duty[CH], m_mot[CH];

    heat_stir_ctrl #(.CH(CH), .TW(TW), .PW(PW), .PRESC(PRESC)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en_i),
        .temp_valid_i (temp_valid),
        .temp_i       (temp_i),
        .setp_i       (setp_i),
        .vel_i        (vel_i),
        .fault_clr_i  (fault_clr),
        .heater_o     (heater_o),
        .motor_o      (motor_o),
        .fault_o      (fault_o),
        .at_temp_o    (at_temp_o),
        .mot_duty_o   (mot_duty_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int raw_duty(input int setp, input int temp);
        int e = setp - temp;
        if (e <= 0) return 0;
        return (e * GAIN > DMAX) ? DMAX : e * GAIN;
    endfunction

    function automatic bit heating(input int s);
        return (s == S_HEAT) || (s == S_HOLD);
    endfunction

    function automatic int nxt(input int s, input int temp, input int setp, input int en, input bit clr);
        int e = setp - temp;
        if (temp >= T_MAX) return S_FAULT;
        if (s == S_FAULT) return (clr && temp < T_CLR) ? S_IDLE : S_FAULT;
        if (en == 0) return S_IDLE;
        if (s == S_IDLE) return S_HEAT;
        return (e <= BAND && e >= -BAND) ? S_HOLD : S_HEAT;
    endfunction

    function automatic int ramp(input int cur, input int tgt);
        if (tgt > cur) return (tgt - cur < STEP) ? tgt : cur + STEP;
        if (cur > tgt) return (cur - tgt < STEP) ? tgt : cur - STEP;
        return cur;
    endfunction

    task automatic set_ch(input int c, input int en, input int setp, input int vel, input int temp);
        en_i[c]              = (en != 0);
        setp_i[c*TW +: TW]   = TW'(setp);
        vel_i[c*PW +: PW]    = PW'(vel);
        n_temp[c] = temp;
        m_en[c]   = en;
        m_setp[c] = setp;
        m_vel[c]  = vel;
    endtask

    // Drive the pending settings for one cycle; the model's mode settles within a few cycles.
    task automatic apply(input bit strobe, input bit clr);
        for (int c = 0; c < CH; c++) begin
            m_st[c] = nxt(m_st[c], m_temp[c], m_setp[c], m_en[c], clr);
            if (strobe) m_temp[c] = n_temp[c];
            repeat (3) m_st[c] = nxt(m_st[c], m_temp[c], m_setp[c], m_en[c], 1'b0);
            if (strobe) temp_i[c*TW +: TW] = TW'(n_temp[c]);
        end
        temp_valid = strobe;
        fault_clr  = clr;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        temp_valid = 1'b0;
        fault_clr  = 1'b0;
        for (int c = 0; c < CH; c++) begin
            hc[c] += int'(heater_o[c]);
            mc[c] += int'(motor_o[c]);
        end
    endtask

    // Runs to the next period boundary; high-time checks only for a full, undisturbed period.
    task automatic window(input logic [CH-1:0] hchk);
        bit full;
        int eh[CH];
        int em[CH];
        full = (cyc % P == 0);
        for (int c = 0; c < CH; c++) begin
            eh[c] = heating(m_st[c]) ? m_duty[c] * PRESC : 0;
            em[c] = m_mot[c] * PRESC;
            if (full) begin
                hc[c] = 0;
                mc[c] = 0;
            end
        end
        do step(); while (cyc % P != 0);
        for (int c = 0; c < CH; c++) begin
            if (full && hchk[c]) check_eq($sformatf("heater_high[%0d]", c), hc[c], eh[c]);
            if (full) check_eq($sformatf("motor_high[%0d]", c), mc[c], em[c]);
            m_duty[c] = heating(m_st[c]) ? raw_duty(m_setp[c], m_temp[c]) : 0;
            m_mot[c]  = ramp(m_mot[c], (m_en[c] != 0) ? m_vel[c] : 0);
            check_eq($sformatf("mot_duty[%0d]", c), int'(mot_duty_o[c*PW +: PW]), m_mot[c]);
            check_eq($sformatf("at_temp[%0d]", c), int'(at_temp_o[c]), int'(m_st[c] == S_HOLD));
            check_eq($sformatf("fault[%0d]", c), int'(fault_o[c]), int'(m_st[c] == S_FAULT));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_heater"}, int'(heater_o), 0);
        check_eq({tag, "_motor"}, int'(motor_o), 0);
        check_eq({tag, "_fault"}, int'(fault_o), 0);
        check_eq({tag, "_at_temp"}, int'(at_temp_o), 0);
        check_eq({tag, "_mot_duty"}, int'(mot_duty_o), 0);
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_st[c] = S_IDLE; m_temp[c] = 0; m_duty[c] = 0; m_mot[c] = 0;
            hc[c] = 0; mc[c] = 0;
        end
        cyc = 0;
    endtask

    initial begin
        model_reset();
        for (int c = 0; c < CH; c++) set_ch(c, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Heat from 90 toward 100: duty 80
        set_ch(0, 1, 100, 0, 90);
        set_ch(1, 0, 0, 0, 20);
        apply(1'b1, 1'b0); window('0); window('1);

        // Into band, out of band, back to heating
        set_ch(0, 1, 100, 0, 99);  apply(1'b1, 1'b0); window('0); window('1);
        set_ch(0, 1, 100, 0, 101); apply(1'b1, 1'b0); window('0); window('1);
        set_ch(0, 1, 100, 0, 104); apply(1'b1, 1'b0); window('0); window('1);

        // Motor soft-start to 130
        set_ch(0, 1, 100, 130, 90); apply(1'b1, 1'b0); window('0);
        repeat (33) window('1);

        // Disable: heater drops next cycle, motor ramps down
        step();
        check_eq("heater_before_disable", int'(heater_o[0]), 1);
        set_ch(0, 0, 100, 130, 90); apply(1'b0, 1'b0);
        step();
        check_eq("heater_after_disable", int'(heater_o[0]), 0);
        window('0);
        repeat (33) window('1);

        // Over-temperature trip, ignored clear, accepted clear
        set_ch(0, 1, 100, 130, 90); apply(1'b1, 1'b0); window('0); window('1);
        step();
        check_eq("heater_before_trip", int'(heater_o[0]), 1);
        set_ch(0, 1, 100, 130, 160); apply(1'b1, 1'b0);
        step(); step();
        check_eq("trip_fault", int'(fault_o[0]), 1);
        check_eq("trip_heater", int'(heater_o[0]), 0);
        window('0); window('1);
        set_ch(0, 1, 100, 130, 155); apply(1'b1, 1'b0); window('0);
        apply(1'b0, 1'b1); window('1);
        set_ch(0, 1, 100, 130, 149); apply(1'b1, 1'b0); window('0);
        apply(1'b0, 1'b1);
        step();
        check_eq("clear_fault", int'(fault_o[0]), 0);
        window('0); window('1);

        // Saturation and negative error
        set_ch(0, 1, 255, 130, 0);   apply(1'b1, 1'b0); window('0); window('1);
        set_ch(0, 1, 100, 130, 120); apply(1'b1, 1'b0); window('0); window('1);

        // Two channels, trip on ch1 only while ch0 keeps its PWM
        set_ch(0, 1, 120, 130, 100);
        set_ch(1, 1, 80, 60, 70);
        apply(1'b1, 1'b0); window('0); window('1);
        set_ch(1, 1, 80, 60, 170); apply(1'b1, 1'b0); window(2'b01); window('1);

        // Random channel settings
        for (int it = 0; it < 12; it++) begin
            for (int c = 0; c < CH; c++)
                set_ch(c, int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 200)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 170)));
            apply(1'b1, $urandom_range(0, 3) == 0);
            window('0); window('1);
        end

        // Mid-period reset, then restart from a clean timebase
        set_ch(0, 1, 120, 200, 100);
        set_ch(1, 1, 130, 200, 100);
        apply(1'b1, 1'b1); window('0); window('1);
        repeat (100) step();
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        set_ch(0, 1, 100, 40, 90);
        set_ch(1, 0, 50, 0, 20);
        apply(1'b1, 1'b0); window('0); window('1); window('1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
